// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module : npu_pkg
// Purpose: Shared types and address-map helpers for the NPU controller.
//          Holds the controller state enum, the parameter-store depth and the
//          element offsets of each field inside the parameter store.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================

// Default network dimensions, used when the integrator does not supply them.
`ifndef N
`define N 4
`endif
`ifndef M
`define M 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package npu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Total number of stored elements: weights1, biases1, weights2, biases2.
  function automatic int cfg_depth(input int in_n, input int hid_n, input int out_n);
    return hid_n * in_n + hid_n + out_n * hid_n + out_n;
  endfunction

  // Element offsets of each field; weights1 always starts at element 0.
  function automatic int off_b1(input int in_n, input int hid_n);
    return hid_n * in_n;
  endfunction

  function automatic int off_w2(input int in_n, input int hid_n);
    return hid_n * in_n + hid_n;
  endfunction

  function automatic int off_b2(input int in_n, input int hid_n, input int out_n);
    return hid_n * in_n + hid_n + out_n * hid_n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/npu_param_store.sv
`default_nettype none
// ============================================================================
// Module : npu_param_store
// Purpose: Addressable register file holding every network parameter, with
//          write range checking and a one-cycle error pulse for rejected
//          writes. The whole store is exposed as one flat vector.
// Ports  : clk, rst_n         - clock, asynchronous active-low reset
//          we_i               - write strobe
//          allow_i            - writes permitted this cycle (controller idle)
//          addr_i, wdata_i    - element address and data
//          err_o              - pulses the cycle after a rejected write
//          mem_o              - element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
// Rev    : 1.0 - initial release
// ============================================================================
module npu_param_store
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 12,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we_i,
  input  logic                        allow_i,
  input  logic [AW-1:0]               addr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  output logic                        err_o,
  output logic [DEPTH*DATA_WIDTH-1:0] mem_o
);

  // Depth widened by one bit so the range compare is exact even when DEPTH
  // is a power of two.
  localparam logic [AW:0] DEPTH_EXT = DEPTH[AW:0];

  logic [DEPTH*DATA_WIDTH-1:0] mem_q;
  logic                        err_q;
  logic                        w_in_range;
  logic                        w_wr_ok;

  assign w_in_range = ({1'b0, addr_i} < DEPTH_EXT);
  assign w_wr_ok    = we_i & allow_i & w_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= we_i & ~(allow_i & w_in_range);
      for (int k = 0; k < DEPTH; k++) begin
        if (w_wr_ok && (addr_i == AW'(k))) begin
          mem_q[k*DATA_WIDTH +: DATA_WIDTH] <= wdata_i;
        end
      end
    end
  end

  assign mem_o = mem_q;
  assign err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/npu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : npu_ctrl
// Purpose: Controller for an external two-layer network datapath. Holds the
//          network parameters, latches an input vector, waits the datapath
//          latency and presents the captured result on a valid/ready port.
// Ports  : clk, rst_n                  - clock, asynchronous active-low reset
//          cfg_we/cfg_addr/cfg_wdata   - parameter-store write port
//          cfg_err                     - one-cycle pulse on rejected write
//          in_valid/in_ready/in_data   - input vector handshake
//          out_valid/out_ready/out_data- result handshake
//          busy                        - high whenever not IDLE
//          dp_*                        - datapath drive / result ports
// Rev    : 1.0 - initial release
// ============================================================================
module npu_ctrl
  import npu_pkg::*;
#(
  parameter int IN_N       = `N,
  parameter int HIDDEN_N   = `M,
  parameter int OUT_N      = `N,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int LAYER_LAT  = 1,
  localparam int CFG_DEPTH = cfg_depth(IN_N, HIDDEN_N, OUT_N),
  localparam int CFG_AW    = $clog2(CFG_DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_we,
  input  logic [CFG_AW-1:0]                  cfg_addr,
  input  logic [DATA_WIDTH-1:0]              cfg_wdata,
  output logic                               cfg_err,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_N*DATA_WIDTH-1:0]         in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OUT_N*DATA_WIDTH-1:0]        out_data,
  output logic                               busy,
  output logic [IN_N*DATA_WIDTH-1:0]         dp_in_vec,
  output logic [HIDDEN_N*IN_N*DATA_WIDTH-1:0] dp_weights1,
  output logic [HIDDEN_N*DATA_WIDTH-1:0]     dp_biases1,
  output logic [OUT_N*HIDDEN_N*DATA_WIDTH-1:0] dp_weights2,
  output logic [OUT_N*DATA_WIDTH-1:0]        dp_biases2,
  input  logic [OUT_N*DATA_WIDTH-1:0]        dp_out_vec
);

  localparam int OFF_B1 = off_b1(IN_N, HIDDEN_N);
  localparam int OFF_W2 = off_w2(IN_N, HIDDEN_N);
  localparam int OFF_B2 = off_b2(IN_N, HIDDEN_N, OUT_N);

  // Counter covers the full two-layer latency; loads 2*LAYER_LAT.
  localparam int              CNT_W    = $clog2(2 * LAYER_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(2 * LAYER_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                           state_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [IN_N*DATA_WIDTH-1:0]       in_vec_q;
  logic [OUT_N*DATA_WIDTH-1:0]      out_q;
  logic [CFG_DEPTH*DATA_WIDTH-1:0]  w_mem;
  logic                             w_idle;

  assign w_idle = (state_q == IDLE);

  npu_param_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (CFG_DEPTH),
    .AW         (CFG_AW)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (cfg_we),
    .allow_i (w_idle),
    .addr_i  (cfg_addr),
    .wdata_i (cfg_wdata),
    .err_o   (cfg_err),
    .mem_o   (w_mem)
  );

  assign dp_weights1 = w_mem[0                   +: HIDDEN_N*IN_N*DATA_WIDTH];
  assign dp_biases1  = w_mem[OFF_B1*DATA_WIDTH   +: HIDDEN_N*DATA_WIDTH];
  assign dp_weights2 = w_mem[OFF_W2*DATA_WIDTH   +: OUT_N*HIDDEN_N*DATA_WIDTH];
  assign dp_biases2  = w_mem[OFF_B2*DATA_WIDTH   +: OUT_N*DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      in_vec_q <= '0;
      out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_vec_q <= in_data;
            cnt_q    <= CNT_LOAD;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // Capture on the last counted edge; "<=" also covers a zero load.
          if (cnt_q <= CNT_ONE) begin
            out_q   <= dp_out_vec;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = w_idle;
  assign out_valid = (state_q == DONE);
  assign busy      = !w_idle;
  assign out_data  = out_q;
  assign dp_in_vec = in_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_npu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_npu_ctrl
// Purpose: Directed self-checking bench for npu_ctrl with a 2x2x2 network,
//          8-bit elements and LAYER_LAT=1. A combinational linear two-layer
//          network stands in for the external datapath.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_npu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic [15:0] dp_in_vec;
  logic [31:0] dp_weights1;
  logic [15:0] dp_biases1;
  logic [31:0] dp_weights2;
  logic [15:0] dp_biases2;
  logic [15:0] dp_out_vec;

  int n_tests = 0;
  int n_fail  = 0;

  npu_ctrl #(
    .IN_N       (2),
    .HIDDEN_N   (2),
    .OUT_N      (2),
    .DATA_WIDTH (8),
    .LAYER_LAT  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .dp_in_vec   (dp_in_vec),
    .dp_weights1 (dp_weights1),
    .dp_biases1  (dp_biases1),
    .dp_weights2 (dp_weights2),
    .dp_biases2  (dp_biases2),
    .dp_out_vec  (dp_out_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Linear two-layer network, results wrapped to 8 bits per element.
  function automatic logic [15:0] net(input logic [15:0] x, input logic [31:0] w1,
                                      input logic [15:0] b1, input logic [31:0] w2,
                                      input logic [15:0] b2);
    logic [7:0]  hid [2];
    logic [15:0] res;
    int          acc;
    res = '0;
    for (int h = 0; h < 2; h++) begin
      acc = $signed(b1[h*8 +: 8]);
      for (int i = 0; i < 2; i++)
        acc = acc + $signed(w1[(h*2+i)*8 +: 8]) * $signed(x[i*8 +: 8]);
      hid[h] = acc[7:0];
    end
    for (int o = 0; o < 2; o++) begin
      acc = $signed(b2[o*8 +: 8]);
      for (int h = 0; h < 2; h++)
        acc = acc + $signed(w2[(o*2+h)*8 +: 8]) * $signed(hid[h]);
      res[o*8 +: 8] = acc[7:0];
    end
    return res;
  endfunction

  assign dp_out_vec = net(dp_in_vec, dp_weights1, dp_biases1, dp_weights2, dp_biases2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0]  cfg_vals [12] = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'h01, 8'h00,
                                 8'h01, 8'h01, 8'h02, 8'hFF, 8'h00, 8'h05};
  logic [15:0] vecs  [3] = '{16'h0403, 16'h0001, 16'h0100};
  logic [15:0] exp_o [3] = '{16'h1814, 16'h0608, 16'h0C05};
  int          hs_cyc [3] = '{0, 0, 0};
  int          n_hs  = 0;
  int          n_out = 0;
  int          cyc   = 0;
  logic        hs_now;
  logic        saw_valid;

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset values, observed before any clock edge.
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_dp_in_vec", dp_in_vec, 16'h0000);
    chk("rst_weights1", dp_weights1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Load the parameter store.
    for (int a = 0; a < 12; a++) begin
      cfg_we    = 1'b1;
      cfg_addr  = 4'(a);
      cfg_wdata = cfg_vals[a];
      step();
      chk("cfg_err_ok", cfg_err, 1'b0);
    end
    cfg_we = 1'b0;
    chk("cfg_weights1", dp_weights1, 32'hFF030201);
    chk("cfg_biases1", dp_biases1, 16'h0001);
    chk("cfg_weights2", dp_weights2, 32'hFF020101);
    chk("cfg_biases2", dp_biases2, 16'h0500);

    // Out-of-range write in IDLE.
    cfg_we    = 1'b1;
    cfg_addr  = 4'd12;
    cfg_wdata = 8'h77;
    step();
    cfg_we = 1'b0;
    chk("oor_err_pulse", cfg_err, 1'b1);
    step();
    chk("oor_err_clear", cfg_err, 1'b0);
    chk("oor_biases2", dp_biases2, 16'h0500);

    // Inference: latency, write rejection during RUN, capture, backpressure.
    in_valid = 1'b1;
    in_data  = 16'h0403;
    step();
    in_valid = 1'b0;
    chk("run_busy", busy, 1'b1);
    chk("run_in_ready", in_ready, 1'b0);
    chk("run_out_valid0", out_valid, 1'b0);
    chk("run_dp_in_vec", dp_in_vec, 16'h0403);
    cfg_we    = 1'b1;
    cfg_addr  = 4'd0;
    cfg_wdata = 8'h05;
    step();
    cfg_we = 1'b0;
    chk("run_rej_err", cfg_err, 1'b1);
    chk("run_rej_w1", dp_weights1[7:0], 8'h01);
    chk("run_out_valid1", out_valid, 1'b0);
    step();
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_out_data", out_data, 16'h1811);
    chk("run_err_clear", cfg_err, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_data", out_data, 16'h1811);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);
    chk("hold_out_data", out_data, 16'h1811);

    // Simultaneous write of biases2[0]=3 and input accept.
    cfg_we    = 1'b1;
    cfg_addr  = 4'd10;
    cfg_wdata = 8'h03;
    in_valid  = 1'b1;
    in_data   = 16'h0403;
    step();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    chk("sim_err", cfg_err, 1'b0);
    chk("sim_biases2", dp_biases2, 16'h0503);
    step();
    step();
    chk("sim_out_valid", out_valid, 1'b1);
    chk("sim_out_data", out_data, 16'h1814);
    out_ready = 1'b1;
    step();
    chk("sim_idle", in_ready, 1'b1);

    // Back-to-back inputs with out_ready held high.
    in_data  = vecs[0];
    in_valid = 1'b1;
    while (n_out < 3 && cyc < 60) begin
      hs_now = in_valid && in_ready;
      if (out_valid) begin
        chk("b2b_out_data", out_data, exp_o[n_out]);
        n_out++;
      end
      if (hs_now) begin
        hs_cyc[n_hs] = cyc;
        n_hs++;
      end
      step();
      cyc++;
      if (hs_now) begin
        if (n_hs < 3) in_data = vecs[n_hs];
        else          in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b_outputs", n_out, 3);
    chk("b2b_inputs", n_hs, 3);
    chk("b2b_space01", hs_cyc[1] - hs_cyc[0], 4);
    chk("b2b_space12", hs_cyc[2] - hs_cyc[1], 4);
    step();

    // Reset asserted in the first RUN cycle.
    in_valid = 1'b1;
    in_data  = 16'h0001;
    step();
    in_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_weights1", dp_weights1, 32'h0);
    chk("mid_rst_biases2", dp_biases2, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_in_ready", in_ready, 1'b1);
    saw_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      saw_valid = saw_valid | out_valid;
    end
    chk("mid_no_out_valid", saw_valid, 1'b0);
    chk("mid_weights1", dp_weights1, 32'h0);
    chk("mid_weights2", dp_weights2, 32'h0);
    chk("mid_out_data", out_data, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
